// File: rtl/rffp_stream_accumulator.sv
// RFFP stream accumulator: reduces a valid/ready burst of RFFP values to one sum.
// Optional build macro RFFP_ACC_ZERO_SKIP_EN: zero beats are counted but not added.

// Combinational RFFP adder: align on the larger exponent, add or subtract mantissas.
// A zero operand (exp and man both 0) sits at the other operand's exponent.
module rffp_adder #(
    parameter int RFFP_EXP_WIDTH = 8,
    parameter int RFFP_MAN_WIDTH = 8
) (
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] i_a,
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] i_b,
    output logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] o_sum
);
    localparam int E = RFFP_EXP_WIDTH;
    localparam int M = RFFP_MAN_WIDTH;

    logic         w_sa;
    logic         w_sb;
    logic [E-1:0] w_ea;
    logic [E-1:0] w_eb;
    logic [M-1:0] w_ma;
    logic [M-1:0] w_mb;
    logic         w_a_zero;
    logic         w_b_zero;
    logic [E-1:0] w_ea_eff;
    logic [E-1:0] w_eb_eff;
    logic [E-1:0] w_emax;
    logic [M-1:0] w_ma_al;
    logic [M-1:0] w_mb_al;
    logic [M:0]   w_sum;
    logic         w_sign;
    logic [M-1:0] w_man;
    logic [E-1:0] w_exp;

    assign w_sa = i_a[E+M];
    assign w_sb = i_b[E+M];
    assign w_ea = i_a[E+M-1:M];
    assign w_eb = i_b[E+M-1:M];
    assign w_ma = i_a[M-1:0];
    assign w_mb = i_b[M-1:0];
    assign w_a_zero = (w_ea == '0) && (w_ma == '0);
    assign w_b_zero = (w_eb == '0) && (w_mb == '0);
    assign w_ea_eff = w_a_zero ? w_eb : w_ea;
    assign w_eb_eff = w_b_zero ? w_ea : w_eb;

    // Align, add/subtract magnitudes, then pack the result exponent and mantissa.
    always_comb begin
        w_emax  = w_ea_eff;
        w_ma_al = w_ma;
        w_mb_al = w_mb;
        w_sum   = '0;
        w_sign  = w_sa;
        w_man   = '0;
        w_exp   = '0;
        if (w_ea_eff >= w_eb_eff) begin
            w_emax  = w_ea_eff;
            w_mb_al = w_mb >> (w_ea_eff - w_eb_eff);
        end else begin
            w_emax  = w_eb_eff;
            w_ma_al = w_ma >> (w_eb_eff - w_ea_eff);
        end
        if (w_sa == w_sb) begin
            w_sum  = {1'b0, w_ma_al} + {1'b0, w_mb_al};
            w_sign = w_sa;
        end else if (w_ma_al >= w_mb_al) begin
            w_sum  = {1'b0, w_ma_al} - {1'b0, w_mb_al};
            w_sign = w_sa;
        end else begin
            w_sum  = {1'b0, w_mb_al} - {1'b0, w_ma_al};
            w_sign = w_sb;
        end
        if (w_ea_eff == w_eb_eff) begin
            w_exp = w_emax + E'(1);
            w_man = w_sum[M:1] + M'(w_sum[0]);
        end else begin
            w_exp = w_emax;
            w_man = w_sum[M-1:0];
        end
    end

    assign o_sum = {w_sign, w_exp, w_man};
endmodule

// Burst accumulator FSM wrapped around the RFFP adder.
module rffp_stream_accumulator #(
    parameter int RFFP_EXP_WIDTH = 8,
    parameter int RFFP_MAN_WIDTH = 8,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] out_data,
    output logic [CNT_WIDTH-1:0]                   out_count
);
    localparam int W = RFFP_EXP_WIDTH + RFFP_MAN_WIDTH + 1;
    localparam int M = RFFP_MAN_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [W-1:0]         r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_data;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic [W-1:0]         w_add;
    logic [W-1:0]         w_acc_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_accept;
    logic                 w_take;
`ifdef RFFP_ACC_ZERO_SKIP_EN
    logic                 w_in_zero;
    logic                 w_acc_zero;
`endif

    rffp_adder #(
        .RFFP_EXP_WIDTH(RFFP_EXP_WIDTH),
        .RFFP_MAN_WIDTH(RFFP_MAN_WIDTH)
    ) u_adder (
        .i_a  (r_acc),
        .i_b  (in_data),
        .o_sum(w_add)
    );

    assign in_ready  = !rst && (r_state != DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_take    = r_out_valid && out_ready;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
`ifdef RFFP_ACC_ZERO_SKIP_EN
    assign w_in_zero  = (in_data[W-2:0] == '0);
    assign w_acc_zero = (r_acc[W-2:0] == '0);
`endif

    // Next partial sum and beat count for an accepted beat.
    always_comb begin
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        if (r_state == IDLE) begin
            w_acc_next = in_data;
            w_cnt_next = CNT_WIDTH'(1);
        end else begin
            w_cnt_next = w_cnt_inc;
`ifdef RFFP_ACC_ZERO_SKIP_EN
            if (w_in_zero)
                w_acc_next = r_acc;
            else if (w_acc_zero)
                w_acc_next = in_data;
            else
                w_acc_next = w_add;
`else
            w_acc_next = w_add;
`endif
        end
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_next = in_last ? DONE : ACCUM;
            end
            ACCUM: begin
                if (w_accept && in_last)
                    w_state_next = DONE;
            end
            DONE: begin
                if (w_take)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Accumulator, counter and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            if (in_last) begin
                r_out_data  <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_valid <= 1'b1;
            end
        end else if (w_take) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // Mantissa width is carried only for readability of the packing above.
    localparam int UNUSED_M = M;
endmodule
